// File: rtl/timer_irq_peri.sv
// ============================================================================
// Module   : timer_irq_peri
// Brief    : 8-bit prescaled bus timer with overflow flag and level interrupt
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module timer_irq_peri #(
    parameter logic [7:0] BASE_ADDR  = 8'h10,
    parameter logic [7:0] RST_RELOAD = 8'hFF
) (
    input  logic       clk_ip,
    input  logic       reset_n_ip,
    input  logic [7:0] addr_ip,
    input  logic [7:0] data_ip,
    input  logic       wr_en_ip,
    input  logic       rd_en_ip,
    output logic [7:0] data_op,
    output logic       hit_op,
    output logic       irq_op
);

    localparam logic [1:0] c_OFF_CTRL   = 2'd0;
    localparam logic [1:0] c_OFF_STAT   = 2'd1;
    localparam logic [1:0] c_OFF_RELOAD = 2'd2;
    localparam logic [1:0] c_OFF_COUNT  = 2'd3;

    logic       r_en_q, r_auto_q, r_irq_en_q, r_ovf_q, r_irq_q;
    logic [2:0] r_ps_q;
    logic [7:0] r_reload_q, r_count_q;
    logic [6:0] r_presc_q;

    logic       w_en_d, w_auto_d, w_irq_en_d, w_ovf_d, w_irq_d;
    logic [2:0] w_ps_d;
    logic [7:0] w_reload_d, w_count_d;
    logic [6:0] w_presc_d;

    logic [8:0] w_off_full;
    logic [1:0] w_off;
    logic       w_hit;
    logic       w_wr_ctrl, w_wr_stat, w_wr_reload, w_wr_count;
    logic [6:0] w_ps_mask;
    logic       w_tick, w_match, w_wrap;
    logic [7:0] w_rdata;

    // Nine-bit subtraction: addresses below BASE_ADDR borrow into bit 8 and miss
    assign w_off_full = {1'b0, addr_ip} - {1'b0, BASE_ADDR};
    assign w_hit      = (w_off_full[8:2] == 7'd0);
    assign w_off      = w_off_full[1:0];

    assign w_wr_ctrl   = w_hit & wr_en_ip & (w_off == c_OFF_CTRL);
    assign w_wr_stat   = w_hit & wr_en_ip & (w_off == c_OFF_STAT);
    assign w_wr_reload = w_hit & wr_en_ip & (w_off == c_OFF_RELOAD);
    assign w_wr_count  = w_hit & wr_en_ip & (w_off == c_OFF_COUNT);

    assign w_ps_mask = ~(7'h7F << r_ps_q);
    assign w_tick    = r_en_q & ((r_presc_q & w_ps_mask) == w_ps_mask);
    assign w_match   = (r_count_q == r_reload_q);
    // A software COUNT load suppresses the whole wrap, including OVF and one-shot stop
    assign w_wrap    = w_tick & w_match & ~w_wr_count;

    always_comb begin
        w_en_d     = r_en_q;
        w_auto_d   = r_auto_q;
        w_irq_en_d = r_irq_en_q;
        w_ps_d     = r_ps_q;
        w_ovf_d    = r_ovf_q;
        w_reload_d = r_reload_q;
        w_count_d  = r_count_q;
        w_presc_d  = r_presc_q + 7'd1;
        w_irq_d    = r_ovf_q & r_irq_en_q;

        if (!r_en_q || w_wr_ctrl || w_wr_count) begin
            w_presc_d = 7'd0;
        end

        if (w_wr_count) begin
            w_count_d = data_ip;
        end else if (w_tick) begin
            w_count_d = w_match ? 8'd0 : r_count_q + 8'd1;
        end

        if (w_wr_stat && data_ip[0]) begin
            w_ovf_d = 1'b0;
        end
        if (w_wrap) begin
            w_ovf_d = 1'b1;
        end

        if (w_wr_ctrl) begin
            w_en_d     = data_ip[0];
            w_auto_d   = data_ip[1];
            w_irq_en_d = data_ip[2];
            w_ps_d     = data_ip[5:3];
        end else if (w_wrap && !r_auto_q) begin
            w_en_d = 1'b0;
        end

        if (w_wr_reload) begin
            w_reload_d = data_ip;
        end
    end

    always_ff @(posedge clk_ip or negedge reset_n_ip) begin
        if (!reset_n_ip) begin
            r_en_q     <= 1'b0;
            r_auto_q   <= 1'b0;
            r_irq_en_q <= 1'b0;
            r_ps_q     <= 3'd0;
            r_ovf_q    <= 1'b0;
            r_reload_q <= RST_RELOAD;
            r_count_q  <= 8'd0;
            r_presc_q  <= 7'd0;
            r_irq_q    <= 1'b0;
        end else begin
            r_en_q     <= w_en_d;
            r_auto_q   <= w_auto_d;
            r_irq_en_q <= w_irq_en_d;
            r_ps_q     <= w_ps_d;
            r_ovf_q    <= w_ovf_d;
            r_reload_q <= w_reload_d;
            r_count_q  <= w_count_d;
            r_presc_q  <= w_presc_d;
            r_irq_q    <= w_irq_d;
        end
    end

    always_comb begin
        w_rdata = 8'h00;
        case (w_off)
            c_OFF_CTRL:   w_rdata = {2'b00, r_ps_q, r_irq_en_q, r_auto_q, r_en_q};
            c_OFF_STAT:   w_rdata = {7'd0, r_ovf_q};
            c_OFF_RELOAD: w_rdata = r_reload_q;
            c_OFF_COUNT:  w_rdata = r_count_q;
        endcase
    end

    assign data_op = (w_hit && rd_en_ip) ? w_rdata : 8'h00;
    assign hit_op  = w_hit;
    assign irq_op  = r_irq_q;

endmodule

`default_nettype wire

// File: tb/tb_timer_irq_peri.sv
// ============================================================================
// Module   : tb_timer_irq_peri
// Brief    : Directed self-checking bench for timer_irq_peri
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_timer_irq_peri;

    localparam logic [7:0] c_BASE   = 8'h10;
    localparam logic [7:0] c_CTRL   = c_BASE + 8'd0;
    localparam logic [7:0] c_STAT   = c_BASE + 8'd1;
    localparam logic [7:0] c_RELOAD = c_BASE + 8'd2;
    localparam logic [7:0] c_COUNT  = c_BASE + 8'd3;

    logic       clk_ip = 1'b0;
    logic       reset_n_ip = 1'b0;
    logic [7:0] addr_ip = 8'h00;
    logic [7:0] data_ip = 8'h00;
    logic       wr_en_ip = 1'b0;
    logic       rd_en_ip = 1'b0;
    logic [7:0] data_op;
    logic       hit_op;
    logic       irq_op;

    int n_vec = 0;
    int n_err = 0;

    timer_irq_peri #(
        .BASE_ADDR  (c_BASE),
        .RST_RELOAD (8'hFF)
    ) u_dut (
        .clk_ip     (clk_ip),
        .reset_n_ip (reset_n_ip),
        .addr_ip    (addr_ip),
        .data_ip    (data_ip),
        .wr_en_ip   (wr_en_ip),
        .rd_en_ip   (rd_en_ip),
        .data_op    (data_op),
        .hit_op     (hit_op),
        .irq_op     (irq_op)
    );

    always #5 clk_ip = ~clk_ip;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge clk_ip);
            #1;
        end
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        addr_ip  = a;
        data_ip  = d;
        wr_en_ip = 1'b1;
        step();
        wr_en_ip = 1'b0;
    endtask

    task automatic rd(input string tag, input logic [7:0] a, input logic [7:0] exp);
        addr_ip  = a;
        rd_en_ip = 1'b1;
        #1;
        chk(tag, data_op, exp);
        rd_en_ip = 1'b0;
    endtask

    task automatic do_reset();
        reset_n_ip = 1'b0;
        step();
        reset_n_ip = 1'b1;
    endtask

    initial begin
        do_reset();
        rd("rst_ctrl", c_CTRL, 8'h00);
        rd("rst_stat", c_STAT, 8'h00);
        rd("rst_reload", c_RELOAD, 8'hFF);
        rd("rst_count", c_COUNT, 8'h00);
        chk("rst_irq", {7'd0, irq_op}, 8'h00);

        // Periodic, PS=0, RELOAD=3
        wr(c_RELOAD, 8'h03);
        wr(c_CTRL, 8'h07);
        rd("per_c0", c_COUNT, 8'h00);
        step();  rd("per_c1", c_COUNT, 8'h01);
        step();  rd("per_c2", c_COUNT, 8'h02);
        step();  rd("per_c3", c_COUNT, 8'h03);
        chk("per_irq_pre", {7'd0, irq_op}, 8'h00);
        step();  rd("per_wrap", c_COUNT, 8'h00);
        rd("per_ovf", c_STAT, 8'h01);
        chk("per_irq_lat", {7'd0, irq_op}, 8'h00);
        step();  chk("per_irq_hi", {7'd0, irq_op}, 8'h01);
        rd("per_c1b", c_COUNT, 8'h01);
        wr(c_STAT, 8'h01);
        rd("per_w1c", c_STAT, 8'h00);
        chk("per_irq_hold", {7'd0, irq_op}, 8'h01);
        step();  chk("per_irq_lo", {7'd0, irq_op}, 8'h00);

        // Asynchronous reset while the timer is running
        reset_n_ip = 1'b0;
        #2;
        chk("arst_irq", {7'd0, irq_op}, 8'h00);
        rd("arst_ctrl", c_CTRL, 8'h00);
        rd("arst_count", c_COUNT, 8'h00);
        rd("arst_reload", c_RELOAD, 8'hFF);
        step();
        reset_n_ip = 1'b1;
        step(2);
        rd("arst_idle", c_COUNT, 8'h00);

        // Prescale PS=2, one-shot, RELOAD=1
        do_reset();
        wr(c_RELOAD, 8'h01);
        wr(c_CTRL, 8'h11);
        step(3); rd("ps_c0", c_COUNT, 8'h00);
        step();  rd("ps_c1", c_COUNT, 8'h01);
        step(3); rd("ps_c1b", c_COUNT, 8'h01);
        rd("ps_noovf", c_STAT, 8'h00);
        step();  rd("ps_wrap", c_COUNT, 8'h00);
        rd("ps_ovf", c_STAT, 8'h01);
        rd("ps_en_off", c_CTRL, 8'h10);

        // One-shot with interrupt, RELOAD=2
        do_reset();
        wr(c_RELOAD, 8'h02);
        wr(c_CTRL, 8'h05);
        step(2); rd("os_c2", c_COUNT, 8'h02);
        step();  rd("os_wrap", c_COUNT, 8'h00);
        rd("os_ctrl", c_CTRL, 8'h04);
        rd("os_ovf", c_STAT, 8'h01);
        step();  chk("os_irq", {7'd0, irq_op}, 8'h01);
        step(3); rd("os_hold", c_COUNT, 8'h00);
        chk("os_irq_hold", {7'd0, irq_op}, 8'h01);
        wr(c_STAT, 8'h01);
        step();  chk("os_irq_clr", {7'd0, irq_op}, 8'h00);

        // Collisions: W1C on wrap edge, COUNT write on tick edge
        do_reset();
        wr(c_RELOAD, 8'h01);
        wr(c_CTRL, 8'h03);
        step();  rd("col_c1", c_COUNT, 8'h01);
        wr(c_STAT, 8'h01);
        rd("col_ovf_kept", c_STAT, 8'h01);
        rd("col_c0", c_COUNT, 8'h00);
        wr(c_STAT, 8'h01);
        rd("col_ovf_clr", c_STAT, 8'h00);
        wr(c_COUNT, 8'h80);
        rd("col_cnt_ld", c_COUNT, 8'h80);
        rd("col_no_ovf", c_STAT, 8'h00);
        step();  rd("col_cnt_inc", c_COUNT, 8'h81);

        // Decode boundaries and read-during-write
        do_reset();
        addr_ip = c_BASE + 8'd4; #1;
        chk("dec_hit_hi", {7'd0, hit_op}, 8'h00);
        addr_ip = c_BASE - 8'd1; #1;
        chk("dec_hit_lo", {7'd0, hit_op}, 8'h00);
        addr_ip = c_COUNT; #1;
        chk("dec_hit_top", {7'd0, hit_op}, 8'h01);
        chk("dec_nord", data_op, 8'h00);
        rd("dec_rd_hi", c_BASE + 8'd4, 8'h00);
        rd("dec_rd_lo", c_BASE - 8'd1, 8'h00);
        wr(c_BASE + 8'd4, 8'hAA);
        wr(c_BASE - 8'd1, 8'h55);
        rd("dec_ctrl", c_CTRL, 8'h00);
        rd("dec_reload", c_RELOAD, 8'hFF);
        rd("dec_count", c_COUNT, 8'h00);
        addr_ip  = c_RELOAD;
        data_ip  = 8'h22;
        wr_en_ip = 1'b1;
        rd_en_ip = 1'b1;
        #1;
        chk("rw_pre", data_op, 8'hFF);
        step();
        wr_en_ip = 1'b0;
        rd_en_ip = 1'b0;
        rd("rw_post", c_RELOAD, 8'h22);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
